riscv_dmem_responder: RTL and testbench

Memory-side responder for the RV32I data port: sits behind the CPU's data-memory byte-lane interface and services word-wide load/store requests arriving with lane-aligned write data and byte selects. Uses a single-request valid/ready handshake, a programmable wait-state counter and per-byte write enables over a word-addressed array. Returns full 32-bit words; sign/zero extension and lane shifting remain on the CPU side.

---
 rtl/riscv_dmem_responder.sv | 124 ++++++++++++
 tb/tb_riscv_dmem_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : riscv_dmem_responder
// Description : Word-wide data-memory responder for an RV32I byte-lane port.
//               Valid/ready request, programmable wait states, one-cycle
//               response strobe, byte-enabled stores, out-of-range flagging.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_dmem_req,
    output logic                o_dmem_ready,
    input  logic [XLEN-1:0]     i_dmem_addr,
    input  logic                i_dmem_wen,
    input  logic [XLEN-1:0]     i_dmem_wr_data,
    input  logic [XLEN/8-1:0]   i_dmem_byte_sel,
    output logic [XLEN-1:0]     o_dmem_rd_data,
    output logic                o_dmem_rvalid,
    output logic                o_dmem_err
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int NBYTES = XLEN / 8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    localparam logic [2:0]      c_wait_load = 3'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam logic [XLEN-1:0] c_depth     = XLEN'(DEPTH_WORDS);

    logic [1:0]         r_state;
    logic [2:0]         r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_wen;
    logic               r_err;
    logic [XLEN-1:0]    r_wr_data;
    logic [NBYTES-1:0]  r_byte_sel;
    logic [XLEN-1:0]    r_mem [DEPTH_WORDS];

    logic [XLEN-1:0]    w_word_num;
    logic               w_oor;
    logic               w_resp;
    logic               w_mem_we;
    logic [XLEN-1:0]    w_rd_word;
    logic               w_unused_addr_lsb;

    // Byte offset within the word is meaningless for a word-wide port.
    assign w_unused_addr_lsb = ^i_dmem_addr[1:0];

    assign w_word_num = {2'b00, i_dmem_addr[XLEN-1:2]};
    assign w_oor      = (w_word_num >= c_depth);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= 3'd0;
            r_idx      <= '0;
            r_wen      <= 1'b0;
            r_err      <= 1'b0;
            r_wr_data  <= '0;
            r_byte_sel <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_dmem_req) begin
                        r_idx      <= i_dmem_addr[IDX_W+1:2];
                        r_wen      <= i_dmem_wen;
                        r_err      <= w_oor;
                        r_wr_data  <= i_dmem_wr_data;
                        r_byte_sel <= i_dmem_byte_sel;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= c_st_wait;
                            r_cnt   <= c_wait_load;
                        end else begin
                            r_state <= c_st_resp;
                        end
                    end
                end
                c_st_wait: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign w_resp   = (r_state == c_st_resp);
    assign w_mem_we = w_resp && r_wen && !r_err;

    // Array has no reset; a reset during WAIT/RESP leaves the state IDLE, so no write.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (r_byte_sel[k]) begin
                    r_mem[r_idx][8*k +: 8] <= r_wr_data[8*k +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[r_idx];

    assign o_dmem_ready   = (r_state == c_st_idle);
    assign o_dmem_rvalid  = w_resp;
    assign o_dmem_err     = w_resp && r_err;
    assign o_dmem_rd_data = (w_resp && !r_wen && !r_err) ? w_rd_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_riscv_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_dmem_responder
// Description : Self-checking bench; three responders (3, 0 and 4 wait states)
//               checked against an array model of the memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [3];
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        rdy [3];
    logic        rv  [3];
    logic        er  [3];
    logic [31:0] rd  [3];

    int          wait_of [3] = '{3, 0, 4};
    logic [31:0] model [3][DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    riscv_dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_dmem_req(req[0]), .o_dmem_ready(rdy[0]),
        .i_dmem_addr(addr), .i_dmem_wen(wen), .i_dmem_wr_data(wdata),
        .i_dmem_byte_sel(sel), .o_dmem_rd_data(rd[0]), .o_dmem_rvalid(rv[0]),
        .o_dmem_err(er[0]));

    riscv_dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_dmem_req(req[1]), .o_dmem_ready(rdy[1]),
        .i_dmem_addr(addr), .i_dmem_wen(wen), .i_dmem_wr_data(wdata),
        .i_dmem_byte_sel(sel), .o_dmem_rd_data(rd[1]), .o_dmem_rvalid(rv[1]),
        .o_dmem_err(er[1]));

    riscv_dmem_responder #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_dmem_req(req[2]), .o_dmem_ready(rdy[2]),
        .i_dmem_addr(addr), .i_dmem_wen(wen), .i_dmem_wr_data(wdata),
        .i_dmem_byte_sel(sel), .o_dmem_rd_data(rd[2]), .o_dmem_rvalid(rv[2]),
        .o_dmem_err(er[2]));

    task automatic preload(input int d, input int idx, input logic [31:0] v);
        case (d)
            0:       u_dut3.r_mem[idx] = v;
            1:       u_dut0.r_mem[idx] = v;
            default: u_dut4.r_mem[idx] = v;
        endcase
        model[d][idx] = v;
    endtask

    // Expected outcome of one request, from the memory rules alone.
    task automatic model_access(input int d, input logic [31:0] a, input logic we,
                                input logic [31:0] wd, input logic [3:0] bs,
                                output logic [31:0] exp_rd, output logic exp_err);
        int idx;
        exp_err = ((a >> 2) >= DEPTH);
        exp_rd  = 32'h0;
        idx     = int'((a >> 2) % DEPTH);
        if (!exp_err) begin
            if (we) begin
                for (int k = 0; k < 4; k++)
                    if (bs[k]) model[d][idx][8*k +: 8] = wd[8*k +: 8];
            end else begin
                exp_rd = model[d][idx];
            end
        end
    endtask

    // One request on instance d; reports response latency, data, error flag,
    // whether ready followed its expected profile, and how many rvalid pulses occurred.
    task automatic run_txn(input int d, input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] bs,
                           output int lat, output logic [31:0] rdat,
                           output logic rerr, output logic rdy_ok, output int pulses);
        int w;
        w      = wait_of[d];
        lat    = -1;
        rdat   = 32'hx;
        rerr   = 1'bx;
        rdy_ok = 1'b1;
        pulses = 0;
        @(negedge clk);
        if (rdy[d] !== 1'b1) rdy_ok = 1'b0;
        addr = a; wen = we; wdata = wd; sel = bs; req[d] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= w + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req[d] = 1'b0;
                addr = $urandom; wen = 1'($urandom); wdata = $urandom; sel = 4'($urandom);
            end
            if (rv[d] === 1'b1) begin
                pulses++;
                if (lat < 0) begin
                    lat  = k;
                    rdat = rd[d];
                    rerr = er[d];
                end
            end
            if (rdy[d] !== (k >= w + 2)) rdy_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        int cnt;
        rst = 1'b1;
        req[0] = 1'b0; req[1] = 1'b0; req[2] = 1'b0;
        addr = 32'h0; wen = 1'b0; wdata = 32'h0; sel = 4'h0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if ({rdy[d], rv[d], er[d], rd[d]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: ready=%b rvalid=%b err=%b rd=%h, want 1 0 0 0",
                         d, rdy[d], rv[d], er[d], rd[d]);
            end
        end
        rst = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (rv[d] !== 1'b0) cnt++;
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL idle_no_rvalid: %0d rvalid cycles, want 0", cnt);
        end
        // Asynchronous reset in the middle of a wait period.
        @(negedge clk);
        addr = 32'h14; wen = 1'b0; sel = 4'hF; req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        n_checks++;
        if (rdy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_wait: ready=%b, want 0", rdy[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({rdy[0], rv[0], er[0], rd[0]} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset: ready=%b rvalid=%b err=%b rd=%h, want 1 0 0 0",
                     rdy[0], rv[0], er[0], rd[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv[0] !== 1'b0) cnt++;
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL no_resp_after_reset: %0d rvalid cycles, want 0", cnt);
        end
    endtask

    task automatic test_load_latency;
        int lat, pulses;
        logic [31:0] r;
        logic e, ok;
        preload(0, 5, 32'hDEADBEEF);
        run_txn(0, 32'h14, 1'b0, $urandom, 4'hF, lat, r, e, ok, pulses);
        n_checks++;
        if (lat != 4 || pulses != 1) begin
            n_fail++;
            $display("FAIL load_latency: rvalid cycle %0d pulses %0d, want 4 and 1", lat, pulses);
        end
        n_checks++;
        if (r !== 32'hDEADBEEF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL load_data: rd=%h err=%b, want deadbeef 0", r, e);
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready_profile: got bad profile, want low T+1..T+4 high T+5");
        end
    endtask

    task automatic test_byte_enable;
        int lat, pulses;
        logic [31:0] r, xr;
        logic e, ok, xe;
        preload(0, 2, 32'h11223344);
        run_txn(0, 32'h08, 1'b1, 32'hAABBCCDD, 4'b0110, lat, r, e, ok, pulses);
        model_access(0, 32'h08, 1'b1, 32'hAABBCCDD, 4'b0110, xr, xe);
        n_checks++;
        if (lat != 4 || r !== 32'h0 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL store_resp: lat=%0d rd=%h err=%b, want 4 0 0", lat, r, e);
        end
        run_txn(0, 32'h08, 1'b0, 32'h0, 4'h0, lat, r, e, ok, pulses);
        n_checks++;
        if (r !== 32'h11BBCC44 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_merge: rd=%h err=%b, want 11bbcc44 0", r, e);
        end
        run_txn(0, 32'h08, 1'b1, 32'h55667788, 4'b0000, lat, r, e, ok, pulses);
        n_checks++;
        if (pulses != 1 || lat != 4) begin
            n_fail++;
            $display("FAIL noop_store_resp: pulses=%0d lat=%0d, want 1 4", pulses, lat);
        end
        run_txn(0, 32'h0B, 1'b0, 32'h0, 4'h0, lat, r, e, ok, pulses);
        n_checks++;
        if (r !== 32'h11BBCC44) begin
            n_fail++;
            $display("FAIL noop_store_unchanged: rd=%h, want 11bbcc44", r);
        end
    endtask

    task automatic test_out_of_range;
        int lat, pulses;
        logic [31:0] r;
        logic e, ok;
        preload(0, 0, 32'h01020304);
        run_txn(0, 32'h1000, 1'b0, 32'h0, 4'hF, lat, r, e, ok, pulses);
        n_checks++;
        if (lat != 4 || e !== 1'b1 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_load: lat=%0d err=%b rd=%h, want 4 1 0", lat, e, r);
        end
        run_txn(0, 32'h1000, 1'b1, 32'hFFFFFFFF, 4'hF, lat, r, e, ok, pulses);
        n_checks++;
        if (e !== 1'b1 || pulses != 1) begin
            n_fail++;
            $display("FAIL oor_store: err=%b pulses=%0d, want 1 1", e, pulses);
        end
        run_txn(0, 32'h0, 1'b0, 32'h0, 4'h0, lat, r, e, ok, pulses);
        n_checks++;
        if (r !== 32'h01020304 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_alias: word0=%h err=%b, want 01020304 0", r, e);
        end
    endtask

    task automatic test_random;
        int lat, pulses;
        logic [31:0] a, wd, r, xr;
        logic [3:0] bs;
        logic we, e, ok, xe;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
                a = ((32'(DEPTH) + ($urandom % 32'h3FFF_F000)) << 2) | 32'($urandom_range(0, 3));
            else
                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            we = 1'($urandom);
            wd = $urandom;
            bs = 4'($urandom);
            run_txn(0, a, we, wd, bs, lat, r, e, ok, pulses);
            model_access(0, a, we, wd, bs, xr, xe);
            n_checks++;
            if (r !== xr || e !== xe) begin
                n_fail++;
                $display("FAIL random_%0d addr=%h wen=%b: rd=%h err=%b, want %h %b",
                         i, a, we, r, e, xr, xe);
            end
            n_checks++;
            if (lat != 4 || pulses != 1 || ok !== 1'b1) begin
                n_fail++;
                $display("FAIL random_timing_%0d: lat=%0d pulses=%0d ready_ok=%b, want 4 1 1",
                         i, lat, pulses, ok);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic exp_rv, acc;
        int cur_word, last_word;
        for (int i = 0; i < 32; i++) preload(1, i, $urandom);
        exp_rv    = 1'b0;
        last_word = 0;
        @(negedge clk);
        cur_word = $urandom_range(0, 31);
        addr = (32'(cur_word) << 2) | 32'($urandom_range(0, 3));
        wen = 1'b0; sel = 4'($urandom); req[1] = 1'b1;
        for (int c = 0; c < 24; c++) begin
            acc = !exp_rv;
            if (acc) last_word = cur_word;
            @(negedge clk);
            exp_rv = acc;
            n_checks++;
            if (rv[1] !== exp_rv || rdy[1] !== !exp_rv) begin
                n_fail++;
                $display("FAIL b2b_handshake_%0d: rvalid=%b ready=%b, want %b %b",
                         c, rv[1], rdy[1], exp_rv, !exp_rv);
            end
            if (exp_rv) begin
                n_checks++;
                if (rd[1] !== model[1][last_word]) begin
                    n_fail++;
                    $display("FAIL b2b_data_%0d word %0d: rd=%h, want %h",
                             c, last_word, rd[1], model[1][last_word]);
                end
            end
            cur_word = $urandom_range(0, 31);
            addr = (32'(cur_word) << 2) | 32'($urandom_range(0, 3));
        end
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_store;
        int lat, pulses, cnt;
        logic [31:0] r;
        logic e, ok;
        preload(2, 7, 32'h0);
        @(negedge clk);
        addr = 32'h1C; wen = 1'b1; wdata = 32'hFFFFFFFF; sel = 4'hF; req[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rdy[2] !== 1'b1 || rv[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_store_reset: ready=%b rvalid=%b, want 1 0", rdy[2], rv[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv[2] !== 1'b0) cnt++;
        end
        n_checks++;
        if (cnt != 0) begin
            n_fail++;
            $display("FAIL mid_store_no_resp: %0d rvalid cycles, want 0", cnt);
        end
        run_txn(2, 32'h1C, 1'b0, 32'h0, 4'h0, lat, r, e, ok, pulses);
        n_checks++;
        if (r !== model[2][7] || lat != 5 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_store_dropped: rd=%h lat=%0d err=%b, want %h 5 0",
                     r, lat, e, model[2][7]);
        end
    endtask

    initial begin
        rst = 1'b1;
        req[0] = 1'b0; req[1] = 1'b0; req[2] = 1'b0;
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < DEPTH; i++) preload(d, i, $urandom);
        test_reset();
        test_load_latency();
        test_byte_enable();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
